// File: rtl/iob_reset_seq_pkg.sv
// rtl/iob_reset_seq_pkg.sv - shared state encoding and counter sizing for the reset sequencer
package iob_reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_WAIT_ACK,
    ST_GAP,
    ST_DONE
  } state_e;

  // One counter covers stretch, gap and timeout, so it is sized for the largest limit.
  function automatic int cnt_width(input int stretch, input int gap, input int timeout);
    int m;
    m = stretch;
    if (gap > m) m = gap;
    if (timeout > m) m = timeout;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/iob_reset_seq_if.sv
// rtl/iob_reset_seq_if.sv - board/domain-facing signal bundle of the reset sequencer
interface iob_reset_seq_if #(
  parameter int N_CH = 4
);

  logic                  cke_i;
  logic                  resetn_i;
  logic                  rst_req_i;
  logic [N_CH-1:0]       ch_ack_i;
  logic [N_CH-1:0]       ch_rst_o;
  logic                  all_ready_o;
  logic [N_CH-1:0]       timeout_o;
  logic [$clog2(N_CH):0] cur_ch_o;

  // Board / reset-domain side: drives the requests and acks, observes the resets.
  modport master (
    output cke_i, resetn_i, rst_req_i, ch_ack_i,
    input  ch_rst_o, all_ready_o, timeout_o, cur_ch_o
  );

  // Sequencer side.
  modport slave (
    input  cke_i, resetn_i, rst_req_i, ch_ack_i,
    output ch_rst_o, all_ready_o, timeout_o, cur_ch_o
  );

endinterface

// File: rtl/iob_reset_seq_sync.sv
// rtl/iob_reset_seq_sync.sv - clock-enabled flop chain synchroniser with reset value
module iob_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cke_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  // Shift the raw input one stage deeper on every enabled edge.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d_i};
  end

  // Chain register; holds completely while the clock enable is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain_q <= {STAGES{RST_VAL}};
    end else if (cke_i) begin
      chain_q <= chain_d;
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/iob_reset_seq.sv
// rtl/iob_reset_seq.sv - stretches board/soft reset and releases N_CH domains one by one
module iob_reset_seq
  import iob_reset_seq_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 16,
  parameter int GAP         = 8,
  parameter int TIMEOUT     = 1024
) (
  input logic            clk_i,
  input logic            rst_i,
  iob_reset_seq_if.slave bus
);

  localparam int CW = cnt_width(STRETCH, GAP, TIMEOUT);
  localparam int KW = $clog2(N_CH) + 1;

  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
  localparam logic [KW-1:0] K_LAST       = KW'(N_CH - 1);
  localparam logic [KW-1:0] K_DONE       = KW'(N_CH);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]   k_q, k_d;
  logic [N_CH-1:0] ch_rst_q, ch_rst_d;
  logic            all_ready_q, all_ready_d;
  logic [N_CH-1:0] timeout_q, timeout_d;

  logic            sync_resetn;
  logic            src;
  logic            ack_cur;
  logic            expired;
  logic [KW-1:0]   cur_ch;

  iob_sync #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .cke_i(bus.cke_i),
    .d_i  (bus.resetn_i),
    .q_o  (sync_resetn)
  );

  // The soft request skips the synchroniser so it acts on the very next edge.
  assign src = ~sync_resetn | bus.rst_req_i;

  // Sequencer next state: stretch, release one channel, wait for ack or timeout, gap, repeat.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    ch_rst_d    = ch_rst_q;
    all_ready_d = all_ready_q;
    timeout_d   = timeout_q;
    ack_cur     = 1'b0;

    // Only the ack of the channel currently being waited on matters.
    for (int i = 0; i < N_CH; i++) begin
      if (KW'(i) == k_q) ack_cur = bus.ch_ack_i[i];
    end
    expired = (TIMEOUT != 0) && (cnt_q == TIMEOUT_LAST);

    if (src) begin
      // Any reset source re-asserts every channel at once and restarts the stretch.
      state_d     = ST_HOLD;
      cnt_d       = '0;
      k_d         = '0;
      ch_rst_d    = '1;
      all_ready_d = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == STRETCH_LAST) begin
            ch_rst_d[0] = 1'b0;
            k_d         = '0;
            cnt_d       = '0;
            state_d     = ST_WAIT_ACK;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_WAIT_ACK: begin
          if (ack_cur || expired) begin
            // An ack arriving on the expiry edge wins, so no flag in that case.
            if (!ack_cur) begin
              for (int i = 0; i < N_CH; i++) begin
                if (KW'(i) == k_q) timeout_d[i] = 1'b1;
              end
            end
            cnt_d = '0;
            if (k_q == K_LAST) begin
              state_d     = ST_DONE;
              all_ready_d = 1'b1;
            end else begin
              state_d = ST_GAP;
            end
          end else if (TIMEOUT != 0) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            for (int i = 0; i < N_CH; i++) begin
              if (KW'(i) == k_q + KW'(1)) ch_rst_d[i] = 1'b0;
            end
            k_d     = k_q + KW'(1);
            cnt_d   = '0;
            state_d = ST_WAIT_ACK;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          // ST_DONE: everything released, nothing moves until a reset source.
        end
      endcase
    end
  end

  // State and output registers; rst_i wins over the clock enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      k_q         <= '0;
      ch_rst_q    <= '1;
      all_ready_q <= 1'b0;
      timeout_q   <= '0;
    end else if (bus.cke_i) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      ch_rst_q    <= ch_rst_d;
      all_ready_q <= all_ready_d;
      timeout_q   <= timeout_d;
    end
  end

  // Reported channel index: 0 while holding, N_CH once everything is released.
  always_comb begin
    cur_ch = k_q;
    if (state_q == ST_HOLD) begin
      cur_ch = '0;
    end else if (state_q == ST_DONE) begin
      cur_ch = K_DONE;
    end
  end

  assign bus.ch_rst_o    = ch_rst_q;
  assign bus.all_ready_o = all_ready_q;
  assign bus.timeout_o   = timeout_q;
  assign bus.cur_ch_o    = cur_ch;

endmodule
